seq_serializer: RTL

Upstream feeder for the FSM5 sequence detector: accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and shifts them out one bit per clock on `seq`, the detector's serial input. It turns word-oriented test and data sources into the continuous bit stream the detector samples every clock. Word boundaries are marked with `seq_last`. Idle gaps are filled with a fixed idle bit.

---
 rtl/seq_serializer_pkg.sv | 14 +
 rtl/seq_serializer_if.sv | 26 ++
 rtl/seq_word_fifo.sv | 66 ++++++
 rtl/seq_serializer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/seq_serializer_pkg.sv
// Shared types and default parameters for the word-to-bit serializer feeding
// the FSM5 sequence detector.
package seq_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int   DEF_WIDTH    = 8;
  localparam int   DEF_DEPTH    = 2;
  localparam logic DEF_IDLE_BIT = 1'b0;

endpackage

// File: rtl/seq_serializer_if.sv
// Parallel-word input handshake plus serial output bundle of the serializer.
interface seq_serializer_if
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             seq;
  logic             seq_valid;
  logic             seq_last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, seq, seq_valid, seq_last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, seq, seq_valid, seq_last, busy
  );

endinterface

// File: rtl/seq_word_fifo.sv
// Small synchronous word FIFO with wrapping pointers and an occupancy count.
module seq_word_fifo
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = do_push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because the count guards reads.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/seq_serializer.sv
// Buffers parallel words and shifts them out one bit per clock on seq, with
// seq_last marking each word's final bit and IDLE_BIT filling gaps.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = DEF_WIDTH,
  parameter int   DEPTH     = DEF_DEPTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  seq_serializer_if.slave  bus
);

  localparam int         BW      = $clog2(WIDTH);
  localparam int         CW      = $clog2(DEPTH) + 1;
  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_SHIFT = SHIFT;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    cnt_q, cnt_d;
  logic             seq_q, seq_d;
  logic             seq_valid_q, seq_valid_d;
  logic             seq_last_q, seq_last_d;
  logic             pop_s, push_s, full_s, empty_s;
  logic [WIDTH-1:0] rdata_s;
  logic [CW-1:0]    count_s;

  assign bus.din_ready = rst & ~full_s;
  assign push_s        = bus.din_valid & bus.din_ready;
  assign bus.seq       = seq_q;
  assign bus.seq_valid = seq_valid_q;
  assign bus.seq_last  = seq_last_q;
  assign bus.busy      = (state_q == S_SHIFT) || (count_s != {CW{1'b0}});

  seq_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .wdata_i (bus.din),
    .pop_i   (pop_s),
    .rdata_o (rdata_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  // FSM, shift register and bit counter next-state logic.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    seq_d       = IDLE_BIT;
    seq_valid_d = 1'b0;
    seq_last_d  = 1'b0;
    pop_s       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          shreg_d = rdata_s;
          cnt_d   = {BW{1'b0}};
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        seq_valid_d = 1'b1;
        seq_last_d  = (cnt_q == LAST_BIT);
        cnt_d       = cnt_q + BW'(1);
        if (MSB_FIRST) begin
          seq_d   = shreg_q[WIDTH-1];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
          seq_d   = shreg_q[0];
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
        // Popping on the last bit keeps consecutive words gap-free.
        if (cnt_q == LAST_BIT) begin
          cnt_d = {BW{1'b0}};
          if (!empty_s) begin
            pop_s   = 1'b1;
            shreg_d = rdata_s;
            state_d = S_SHIFT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered serial outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      shreg_q     <= {WIDTH{1'b0}};
      cnt_q       <= {BW{1'b0}};
      seq_q       <= IDLE_BIT;
      seq_valid_q <= 1'b0;
      seq_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      seq_valid_q <= seq_valid_d;
      seq_last_q  <= seq_last_d;
    end
  end

endmodule
